// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and sizes for the AES word loader
package aes_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } loader_state_t;

  localparam int KEY_WORDS = 8;
  localparam int BLK_WORDS = 4;
  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 256;

endpackage

// File: rtl/aes_word_ser.sv
// rtl/aes_word_ser.sv - 128-bit block to 4x32-bit word serialiser with valid/ready
module aes_word_ser
  import aes_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [AES_BLK_W-1:0] ct,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_data,
  output logic                 last
);

  logic [AES_BLK_W-1:0] ct_reg;
  logic [1:0]           out_cnt;

  // Word select comes straight from the held block, so data cannot move while stalled.
  assign out_data = ct_reg[AES_BLK_W - 1 - WORD_W * int'(out_cnt) -: WORD_W];
  assign last     = out_valid && out_ready && (out_cnt == 2'(BLK_WORDS - 1));

  // Capture the block on load, then advance one word per handshake until all four leave.
  always_ff @(posedge clk) begin
    if (reset) begin
      ct_reg    <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      ct_reg    <= ct;
      out_cnt   <= '0;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_cnt <= out_cnt + 2'd1;
      if (out_cnt == 2'(BLK_WORDS - 1)) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/aes_word_loader.sv
// rtl/aes_word_loader.sv - word-serial key/plaintext loader and ciphertext unloader for the AES core
module aes_word_loader
  import aes_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [WORD_W-1:0]    key_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_data,
  output logic                 aes_start,
  output logic [AES_BLK_W-1:0] aes_plaintext,
  output logic [AES_KEY_W-1:0] aes_key,
  input  logic [AES_BLK_W-1:0] aes_ciphertext,
  input  logic                 aes_done,
  output logic                 busy
);

  loader_state_t state;
  logic [2:0]    key_cnt;
  logic [1:0]    pt_cnt;
  logic          key_loaded;
  logic          key_hs;
  logic          pt_hs;
  logic          ser_load;
  logic          ser_last;

  // Keys are only taken between blocks; a pending key word beats the start of a new block.
  assign key_ready = !reset && (state == LOAD) && (pt_cnt == 2'd0);
  assign in_ready  = !reset && (state == LOAD) && key_loaded && !(key_valid && (pt_cnt == 2'd0));
  assign key_hs    = key_valid && key_ready;
  assign pt_hs     = in_valid && in_ready;
  assign ser_load  = (state == WAIT) && aes_done;

  aes_word_ser #(
    .WORD_W(WORD_W)
  ) u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (ser_load),
    .ct       (aes_ciphertext),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .last     (ser_last)
  );

  // Control FSM: gather key and block words, kick the core, wait for it, drain the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= LOAD;
      key_cnt       <= '0;
      pt_cnt        <= '0;
      key_loaded    <= 1'b0;
      aes_key       <= '0;
      aes_plaintext <= '0;
      aes_start     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      aes_start <= 1'b0;
      case (state)
        LOAD: begin
          if (key_hs) begin
            aes_key    <= {aes_key[AES_KEY_W-WORD_W-1:0], key_data};
            key_cnt    <= key_cnt + 3'd1;
            // Any word but the last leaves the key incomplete, so a rewrite blocks plaintext.
            key_loaded <= (key_cnt == 3'(KEY_WORDS - 1));
          end
          if (pt_hs) begin
            aes_plaintext <= {aes_plaintext[AES_BLK_W-WORD_W-1:0], in_data};
            pt_cnt        <= pt_cnt + 2'd1;
            if (pt_cnt == 2'(BLK_WORDS - 1)) begin
              state     <= START;
              aes_start <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          if (aes_done) begin
            state <= UNLOAD;
          end
        end
        UNLOAD: begin
          if (ser_last) begin
            state <= LOAD;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_word_loader.sv
// tb/tb_aes_word_loader.sv - directed self-checking bench for aes_word_loader
module tb_aes_word_loader;

  localparam logic [255:0] K1  = {32'h80000000, 224'h0};
  localparam logic [127:0] PT1 = 128'h0;
  localparam logic [127:0] CT1 = 128'he35a6dcb_19b201a0_1ebcfa8a_a22b5759;
  localparam logic [255:0] K2  = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
  localparam logic [127:0] PT2 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] CT2 = 128'h8ea2b7ca_516745bf_eafc4990_4b496089;

  logic         clk;
  logic         reset;
  logic         key_valid;
  logic         key_ready;
  logic [31:0]  key_data;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         aes_start;
  logic [127:0] aes_plaintext;
  logic [255:0] aes_key;
  logic [127:0] aes_ciphertext;
  logic         aes_done;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  int start_cnt = 0;
  int fired     = 0;
  int core_lat  = 3;
  int kick_req  = 0;

  aes_word_loader #(
    .WORD_W(32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .key_data      (key_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .aes_start     (aes_start),
    .aes_plaintext (aes_plaintext),
    .aes_key       (aes_key),
    .aes_ciphertext(aes_ciphertext),
    .aes_done      (aes_done),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endfunction

  function automatic logic [127:0] core_result(input logic [255:0] k, input logic [127:0] p);
    if (k == K1 && p == PT1) return CT1;
    if (k == K2 && p == PT2) return CT2;
    return 128'hbad0bad0_bad0bad0_bad0bad0_bad0bad0;
  endfunction

  // Stand-in for the AES core: fixed latency after start, result from known vectors.
  initial begin
    int           core_cnt;
    int           kick_seen;
    logic [255:0] lk;
    logic [127:0] lp;
    core_cnt  = 0;
    kick_seen = 0;
    lk = '0;
    lp = '0;
    aes_done       = 1'b0;
    aes_ciphertext = '0;
    forever begin
      @(negedge clk);
      aes_done = 1'b0;
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          aes_done       = 1'b1;
          aes_ciphertext = core_result(lk, lp);
          fired++;
        end
      end
      if (kick_req != kick_seen) begin
        kick_seen = kick_req;
        core_cnt  = 2;
      end
      if (aes_start) begin
        start_cnt++;
        core_cnt = core_lat;
        lk = aes_key;
        lp = aes_plaintext;
      end
    end
  end

  task automatic push_key(input logic [31:0] w);
    bit hs;
    hs = 1'b0;
    key_valid = 1'b1;
    key_data  = w;
    for (int i = 0; i < 30 && !hs; i++) begin
      #1;
      hs = key_ready;
      @(posedge clk);
      @(negedge clk);
    end
    key_valid = 1'b0;
    if (!hs) chk("key_push_timeout", 256'(hs), 256'(1));
  endtask

  task automatic push_pt(input logic [31:0] w);
    bit hs;
    hs = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 30 && !hs; i++) begin
      #1;
      hs = in_ready;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!hs) chk("pt_push_timeout", 256'(hs), 256'(1));
  endtask

  task automatic load_key(input logic [255:0] k);
    for (int i = 0; i < 8; i++) push_key(k[255 - 32*i -: 32]);
  endtask

  task automatic load_pt(input logic [127:0] p);
    for (int i = 0; i < 4; i++) push_pt(p[127 - 32*i -: 32]);
  endtask

  task automatic collect(input bit toggle, output logic [127:0] got);
    logic [31:0] held;
    bit          stalled;
    int          nhs;
    held    = '0;
    stalled = 1'b0;
    nhs     = 0;
    got     = '0;
    for (int c = 0; c < 100 && nhs < 4; c++) begin
      out_ready = toggle ? (c % 2 == 0) : 1'b1;
      #1;
      if (out_valid) begin
        if (stalled) chk("stall_hold", 256'(out_data), 256'(held));
        if (out_ready) begin
          got     = {got[95:0], out_data};
          nhs++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = out_data;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("hs_count", 256'(nhs), 256'(4));
    #1;
    chk("out_valid_after", 256'(out_valid), 256'(0));
    chk("busy_after", 256'(busy), 256'(0));
  endtask

  task automatic check_reset_values();
    chk("rst_key_ready", 256'(key_ready), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_data", 256'(out_data), 256'(0));
    chk("rst_aes_start", 256'(aes_start), 256'(0));
    chk("rst_plaintext", 256'(aes_plaintext), 256'(0));
    chk("rst_key", aes_key, 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
  endtask

  typedef struct {
    bit           do_key;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  initial begin
    vec_t         vecs [3];
    logic [127:0] got;
    int           s0;
    int           f0;
    bit           seen;

    vecs[0] = '{do_key: 1'b1, key: K1, pt: PT1, ct: CT1};
    vecs[1] = '{do_key: 1'b1, key: K2, pt: PT2, ct: CT2};
    vecs[2] = '{do_key: 1'b0, key: K2, pt: PT2, ct: CT2};

    reset     = 1'b1;
    key_valid = 1'b0;
    key_data  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_key_ready", 256'(key_ready), 256'(1));
    chk("post_rst_in_ready", 256'(in_ready), 256'(0));
    @(negedge clk);

    // Table: full key+block, second key, then a block reusing the previous key.
    for (int v = 0; v < 3; v++) begin
      s0 = start_cnt;
      if (vecs[v].do_key) load_key(vecs[v].key);
      load_pt(vecs[v].pt);
      collect(1'b0, got);
      chk($sformatf("v%0d_start_pulses", v), 256'(start_cnt - s0), 256'(1));
      chk($sformatf("v%0d_key_reg", v), aes_key, vecs[v].key);
      chk($sformatf("v%0d_pt_reg", v), 256'(aes_plaintext), 256'(vecs[v].pt));
      chk($sformatf("v%0d_ct", v), 256'(got), 256'(vecs[v].ct));
    end

    // A done pulse outside WAIT must not produce output.
    @(negedge clk);
    kick_req++;
    seen = 1'b0;
    f0   = fired;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("stray_done_fired", 256'(fired - f0), 256'(1));
    chk("stray_done_ignored", 256'(seen), 256'(0));

    // Stalled output with out_ready toggling, same key.
    s0 = start_cnt;
    load_pt(PT2);
    collect(1'b1, got);
    chk("stall_ct", 256'(got), 256'(CT2));
    chk("stall_start_pulses", 256'(start_cnt - s0), 256'(1));

    // Plaintext offered before any key is loaded.
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = '0;
    seen     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (in_ready) seen = 1'b1;
      @(negedge clk);
    end
    chk("no_key_in_ready", 256'(seen), 256'(0));
    for (int i = 0; i < 7; i++) begin
      push_key(K1[255 - 32*i -: 32]);
      #1;
      if (in_ready) seen = 1'b1;
    end
    chk("partial_key_in_ready", 256'(seen), 256'(0));
    push_key(K1[31:0]);
    #1;
    chk("key_done_in_ready", 256'(in_ready), 256'(1));
    in_valid = 1'b0;
    @(negedge clk);
    s0 = start_cnt;
    load_pt(PT1);
    collect(1'b0, got);
    chk("late_pt_ct", 256'(got), 256'(CT1));
    chk("late_pt_start_pulses", 256'(start_cnt - s0), 256'(1));

    // Reset while waiting on the core; the late done must be ignored.
    core_lat = 8;
    load_pt(PT1);
    @(negedge clk);
    #1;
    chk("wait_busy", 256'(busy), 256'(1));
    chk("wait_out_valid", 256'(out_valid), 256'(0));
    f0    = fired;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("aborted_done_fired", 256'(fired - f0), 256'(1));
    chk("aborted_no_output", 256'(seen), 256'(0));
    chk("aborted_busy", 256'(busy), 256'(0));
    core_lat = 3;
    s0 = start_cnt;
    load_key(K2);
    load_pt(PT2);
    collect(1'b0, got);
    chk("fresh_ct", 256'(got), 256'(CT2));
    chk("fresh_start_pulses", 256'(start_cnt - s0), 256'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_word_loader.md
# aes_word_loader

Word-serial front/back end for the AES-256 core. Collects a 256-bit key (8 words) and a 128-bit plaintext block (4 words) over 32-bit valid/ready streams, and pulses the core's `start`. It then waits for `done`, captures the 128-bit ciphertext and streams it back out as 4 words. It sits directly between the system bus adapter and the `AES` core: it drives the core's `plaintext`, `key` and `start`, and consumes its `ciphertext` and `done`.

## Interface
- `WORD_W`, 32: stream word width; fixed at 32, other values unsupported.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `key_valid`  in  1  key word offered.
- `key_ready`  out  1  key word accepted when `key_valid && key_ready`.
- `key_data`  in  32  key word; first word = key[255:224], eighth = key[31:0].
- `in_valid`  in  1  plaintext word offered.
- `in_ready`  out  1  plaintext word accepted on handshake.
- `in_data`  in  32  plaintext word; first = pt[127:96], fourth = pt[31:0].
- `out_valid`  out  1  ciphertext word available.
- `out_ready`  in  1  downstream accepts word.
- `out_data`  out  32  ciphertext word; first = ct[127:96].
- `aes_start`  out  1  one-cycle start pulse to core.
- `aes_plaintext`  out  128  registered block to core.
- `aes_key`  out  256  registered key to core.
- `aes_ciphertext`  in  128  core result.
- `aes_done`  in  1  core completion.
- `busy`  out  1  high in START, WAIT, UNLOAD.

## Operation
- States: LOAD, START, WAIT, UNLOAD. Reset state: LOAD.
- Key path:
  - `key_ready = (state==LOAD) && (pt_cnt==0)`.
  - Each accepted key word is shifted into `aes_key` from the LSB side, and `key_cnt` (3 bit) increments.
  - The first word of a key clears `key_loaded`. The eighth word sets `key_loaded` and wraps `key_cnt` to 0.
  - The key persists across blocks until reset or a new key write.
- Plaintext path:
  - `in_ready = (state==LOAD) && key_loaded && !(key_valid && pt_cnt==0)`. Key words win over a block start.
  - Each accepted word is shifted into `aes_plaintext`, and `pt_cnt` (2 bit) increments.
  - On the 4th word, `pt_cnt` wraps to 0 and the FSM goes to START.
- START: `aes_start`=1 for exactly this one cycle, then go to WAIT unconditionally.
- WAIT:
  - When `aes_done`=1, latch `aes_ciphertext` into the output register and go to UNLOAD.
  - `aes_done` is ignored in every state except WAIT.
- UNLOAD:
  - `out_valid`=1 and `out_data` = `ct[127-32*out_cnt -: 32]`.
  - On each handshake `out_cnt` increments. After the 4th handshake go to LOAD.
  - `out_data` is stable while `out_valid && !out_ready`.
- Reset values: `key_ready`=0 (LOAD, but `pt_cnt`=0 gives 1 after the reset cycle), `in_ready`=0, `out_valid`=0, `out_data`=0, `aes_start`=0, `aes_plaintext`=0, `aes_key`=0, `busy`=0, `key_loaded`=0, all counters 0.
- Reset mid-operation (any state) returns to LOAD and discards the partial key, block and ciphertext. Any in-flight core result is ignored.
- A partial key (`key_cnt`≠0) blocks plaintext, because `key_loaded`=0.

## Timing
- The 4th plaintext handshake at edge N puts the FSM in START during cycle N→N+1. `aes_start` is high for that cycle and the core samples it at edge N+1.
- The first cycle `aes_done` is seen in WAIT is edge D. `out_valid` rises after D, so the first word is available the cycle after D.
- With `out_ready` held high, UNLOAD lasts 4 cycles, and `in_ready` can be high again on the 5th cycle after D.
- Throughput: 4 load cycles + 1 start + core latency + 1 + 4 unload cycles.
- The output register holds its value after UNLOAD until the next capture.

## Structure
- Shared package `aes_pkg`:
  - state enum `loader_state_t` {LOAD, START, WAIT, UNLOAD};
  - localparams `KEY_WORDS`=8, `BLK_WORDS`=4, `AES_BLK_W`=128, `AES_KEY_W`=256.
- One natural sub-module: `aes_word_ser`, the 128→4×32 output serialiser with valid/ready and `out_cnt`. Everything else stays in the top.
- The `AES` core is instantiated by the parent, not inside this block.

## Test plan
- Reset, then load key `8000…0` (words `80000000`, then 7×0) and plaintext 4×`00000000`.
  - Required: exactly one `aes_start` pulse.
  - Required output words `e35a6dcb`, `19b201a0`, `1ebcfa8a`, `a22b5759`.
- FIPS-197 vector: key words `00010203` … `1c1d1e1f`, plaintext `00112233` `44556677` `8899aabb` `ccddeeff`.
  - Required output `8ea2b7ca` `516745bf` `eafc4990` `4b496089`.
- Offer plaintext before any key.
  - Required: `in_ready`=0 throughout.
  - After the 8 key words, `in_ready`=1 on the next cycle.
- Back-to-back blocks with one key load.
  - Required: the key is reused, both results are correct, and `busy` returns to 0 between blocks.
- `out_ready` toggled 1-0-1 each cycle.
  - Required: `out_data` holds while stalled, no words are duplicated or dropped, and there are exactly 4 output handshakes.
- Assert reset while in WAIT, then complete a fresh block.
  - Required: all outputs go to reset values the next cycle, and the late `aes_done` of the aborted block produces no output.
  - Required: the fresh block gives the correct ciphertext.
